// File: rtl/sec_clock_display_if.sv
// Bundle between sec_clock_display and the board/test side:
// seconds toggle and controls in, BCD time and display drive out.
interface sec_clock_display_if;
  logic        sec_toggle;
  logic        run;
  logic        clr;
  logic [15:0] time_bcd;
  logic        hour_p;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  dig_n;

  modport slave (
    input  sec_toggle, run, clr,
    output time_bcd, hour_p, seg_n, dp_n, dig_n
  );

  modport master (
    output sec_toggle, run, clr,
    input  time_bcd, hour_p, seg_n, dp_n, dig_n
  );
endinterface

// File: rtl/sec_clock_display.sv
// MM:SS seconds clock fed by a 1 s toggle, with 4-digit 7-seg scan.
// Optional SEC_CLOCK_DP_BLINK_EN: blinking dp on digit 2 as a colon.
module sec_clock_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input logic             clk,
  input logic             reset,
  sec_clock_display_if.slave bus
);

  localparam int CW = $clog2(SCAN_DIV);

  logic          sync1, sync2, sync2_d;
  logic [2:0]    arm_sr;
  logic          tick_r;
  logic [3:0]    s1, s10, m1, m10;
  logic          hour_p;
  logic [CW-1:0] cnt;
  logic [1:0]    idx, idx_nx;
  logic          tc;
  logic [3:0]    nib;
  logic [6:0]    seg_n;
  logic [3:0]    dig_n;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    s = 7'b1111111;
    case (v)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // arm_sr[2] rises only after sync2_d holds a real sample,
  // so a level present at release never counts as an edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
      arm_sr  <= 3'b000;
      tick_r  <= 1'b0;
    end else begin
      sync1   <= bus.sec_toggle;
      sync2   <= sync1;
      sync2_d <= sync2;
      arm_sr  <= {arm_sr[1:0], 1'b1};
      tick_r  <= arm_sr[2] & (sync2 ^ sync2_d);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1     <= 4'd0;
      s10    <= 4'd0;
      m1     <= 4'd0;
      m10    <= 4'd0;
      hour_p <= 1'b0;
    end else if (bus.clr) begin
      s1     <= 4'd0;
      s10    <= 4'd0;
      m1     <= 4'd0;
      m10    <= 4'd0;
      hour_p <= 1'b0;
    end else begin
      hour_p <= 1'b0;
      if (tick_r && bus.run) begin
        if (s1 != 4'd9) begin
          s1 <= s1 + 4'd1;
        end else begin
          s1 <= 4'd0;
          if (s10 != 4'd5) begin
            s10 <= s10 + 4'd1;
          end else begin
            s10 <= 4'd0;
            if (m1 != 4'd9) begin
              m1 <= m1 + 4'd1;
            end else begin
              m1 <= 4'd0;
              if (m10 != 4'd5) begin
                m10 <= m10 + 4'd1;
              end else begin
                m10    <= 4'd0;
                hour_p <= 1'b1;
              end
            end
          end
        end
      end
    end
  end

  assign tc     = (cnt == CW'(SCAN_DIV - 1));
  assign idx_nx = tc ? idx + 2'd1 : idx;

  always_comb begin
    nib = s1;
    case (idx_nx)
      2'd0: nib = s1;
      2'd1: nib = s10;
      2'd2: nib = m1;
      2'd3: nib = m10;
      default: nib = s1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      idx   <= 2'd0;
      dig_n <= 4'b1110;
      seg_n <= 7'b1000000;
    end else if (tc) begin
      cnt   <= '0;
      idx   <= idx_nx;
      dig_n <= ~(4'b0001 << idx_nx);
      seg_n <= seg7(nib);
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

`ifdef SEC_CLOCK_DP_BLINK_EN
  logic dp_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dp_n <= 1'b1;
    end else begin
      dp_n <= ~((idx_nx == 2'd2) & sync2);
    end
  end

  assign bus.dp_n = dp_n;
`else
  assign bus.dp_n = 1'b1;
`endif

  assign bus.time_bcd = {m10, m1, s10, s1};
  assign bus.hour_p   = hour_p;
  assign bus.seg_n    = seg_n;
  assign bus.dig_n    = dig_n;

endmodule

// File: tb/tb_sec_clock_display.sv
// Directed bench for sec_clock_display with SCAN_DIV=4.
// Define SEC_CLOCK_DP_BLINK_EN to also cover the blinking dp.
module tb_sec_clock_display;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   fails = 0;

  sec_clock_display_if bus();

  sec_clock_display #(.SCAN_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] DIG [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [6:0] SEG [4] = '{7'b0011001, 7'b0110000,
                                     7'b0100100, 7'b1111001};

  task automatic do_reset(input logic tog);
    @(negedge clk);
    reset = 1'b0;
    bus.sec_toggle = tog;
    bus.run = 1'b1;
    bus.clr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic toggle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.sec_toggle = ~bus.sec_toggle;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic align(output bit ok);
    logic [3:0] prev;
    ok = 1'b0;
    prev = bus.dig_n;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (bus.dig_n == 4'b1110 && prev != 4'b1110) begin
        ok = 1'b1;
        break;
      end
      prev = bus.dig_n;
    end
  endtask

  task automatic test_reset;
    int bad;
    @(negedge clk);
    reset = 1'b0;
    bus.sec_toggle = 1'b1;
    bus.run = 1'b1;
    bus.clr = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.time_bcd, bus.hour_p, bus.seg_n, bus.dp_n, bus.dig_n} !==
        {16'h0000, 1'b0, 7'b1000000, 1'b1, 4'b1110}) begin
      fails++;
      $display("FAIL reset_vals got %h/%b/%b/%b/%b want 0000/0/1000000/1/1110",
               bus.time_bcd, bus.hour_p, bus.seg_n, bus.dp_n, bus.dig_n);
    end
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.time_bcd !== 16'h0000 || bus.hour_p !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL high_at_release got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_latency;
    do_reset(1'b0);
    bus.sec_toggle = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.time_bcd !== 16'h0000) begin
      fails++;
      $display("FAIL lat_edge3 got %h want 0000", bus.time_bcd);
    end
    @(negedge clk);
    checks++;
    if (bus.time_bcd !== 16'h0001) begin
      fails++;
      $display("FAIL lat_edge4 got %h want 0001", bus.time_bcd);
    end
    repeat (6) @(negedge clk);
    bus.sec_toggle = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.time_bcd !== 16'h0002) begin
      fails++;
      $display("FAIL fall_edge got %h want 0002", bus.time_bcd);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (bus.time_bcd !== 16'h0002) begin
      fails++;
      $display("FAIL one_per_edge got %h want 0002", bus.time_bcd);
    end
  endtask

  task automatic test_wrap;
    int hp;
    do_reset(1'b0);
    toggle(59);
    checks++;
    if (bus.time_bcd !== 16'h0059) begin
      fails++;
      $display("FAIL t59 got %h want 0059", bus.time_bcd);
    end
    toggle(1);
    checks++;
    if (bus.time_bcd !== 16'h0100) begin
      fails++;
      $display("FAIL t60 got %h want 0100", bus.time_bcd);
    end
    toggle(540);
    checks++;
    if (bus.time_bcd !== 16'h1000) begin
      fails++;
      $display("FAIL t600 got %h want 1000", bus.time_bcd);
    end
    toggle(2999);
    checks++;
    if (bus.time_bcd !== 16'h5959 || bus.hour_p !== 1'b0) begin
      fails++;
      $display("FAIL t3599 got %h/%b want 5959/0", bus.time_bcd, bus.hour_p);
    end
    hp = 0;
    bus.sec_toggle = ~bus.sec_toggle;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.hour_p === 1'b1) hp++;
    end
    checks++;
    if (bus.time_bcd !== 16'h0000 || hp != 1) begin
      fails++;
      $display("FAIL hour_wrap got %h/%0d want 0000/1", bus.time_bcd, hp);
    end
  endtask

  task automatic test_clr;
    do_reset(1'b0);
    toggle(83);
    checks++;
    if (bus.time_bcd !== 16'h0123) begin
      fails++;
      $display("FAIL pre_clr got %h want 0123", bus.time_bcd);
    end
    bus.sec_toggle = ~bus.sec_toggle;
    repeat (3) @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    checks++;
    if (bus.time_bcd !== 16'h0000) begin
      fails++;
      $display("FAIL clr_tick got %h want 0000", bus.time_bcd);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (bus.time_bcd !== 16'h0000) begin
      fails++;
      $display("FAIL clr_hold got %h want 0000", bus.time_bcd);
    end
    bus.run = 1'b0;
    toggle(5);
    checks++;
    if (bus.time_bcd !== 16'h0000) begin
      fails++;
      $display("FAIL run0 got %h want 0000", bus.time_bcd);
    end
    bus.run = 1'b1;
    repeat (6) @(negedge clk);
    toggle(1);
    checks++;
    if (bus.time_bcd !== 16'h0001) begin
      fails++;
      $display("FAIL resume got %h want 0001", bus.time_bcd);
    end
  endtask

  task automatic test_scan;
    bit ok;
    int bad;
    do_reset(1'b0);
    toggle(754);
    repeat (8) @(negedge clk);
    checks++;
    if (bus.time_bcd !== 16'h1234) begin
      fails++;
      $display("FAIL scan_time got %h want 1234", bus.time_bcd);
    end
    align(ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL scan_align got timeout want dig_n 1110");
    end
    bad = 0;
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < 4; s++)
        for (int c = 0; c < 4; c++) begin
          if (bus.dig_n !== DIG[s] || bus.seg_n !== SEG[s]) begin
            bad++;
            $display("FAIL scan_r%0d_s%0d_c%0d got %b/%b want %b/%b", r, s, c,
                     bus.dig_n, bus.seg_n, DIG[s], SEG[s]);
          end
          @(negedge clk);
        end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL scan_seq got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_dp;
    bit ok;
    int bad;
    logic exp;
    for (int p = 0; p < 2; p++) begin
      bus.sec_toggle = (p == 0);
      repeat (4) @(negedge clk);
      align(ok);
      checks++;
      if (!ok) begin
        fails++;
        $display("FAIL dp_align got timeout want dig_n 1110");
      end
      bad = 0;
      for (int s = 0; s < 4; s++)
        for (int c = 0; c < 4; c++) begin
`ifdef SEC_CLOCK_DP_BLINK_EN
          exp = !(p == 0 && s == 2);
`else
          exp = 1'b1;
`endif
          if (bus.dp_n !== exp) bad++;
          @(negedge clk);
        end
      checks++;
      if (bad != 0) begin
        fails++;
        $display("FAIL dp_phase%0d got %0d bad cycles want 0", p, bad);
      end
    end
  endtask

  task automatic test_reset_mid;
    toggle(3);
    checks++;
    if (bus.time_bcd === 16'h0000) begin
      fails++;
      $display("FAIL mid_pre got %h want nonzero", bus.time_bcd);
    end
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.time_bcd, bus.hour_p, bus.seg_n, bus.dp_n, bus.dig_n} !==
        {16'h0000, 1'b0, 7'b1000000, 1'b1, 4'b1110}) begin
      fails++;
      $display("FAIL mid_reset got %h/%b/%b/%b/%b want 0000/0/1000000/1/1110",
               bus.time_bcd, bus.hour_p, bus.seg_n, bus.dp_n, bus.dig_n);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (bus.time_bcd !== 16'h0000) begin
      fails++;
      $display("FAIL post_reset got %h want 0000", bus.time_bcd);
    end
  endtask

  initial begin
    bus.sec_toggle = 1'b0;
    bus.run = 1'b1;
    bus.clr = 1'b0;
    test_reset;
    test_latency;
    test_wrap;
    test_clr;
    test_scan;
    test_dp;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
